// File: rtl/clk_down_pkg.sv
// Shared types and constants for the multi-channel fast-to-slow transfer block.
package clk_down_pkg;

  // LATEST keeps only the newest word per channel; FIFO queues words with backpressure.
  typedef enum logic {
    XFER_LATEST = 1'b0,
    XFER_FIFO   = 1'b1
  } xfer_mode_e;

  // Number of flops that resynchronise slow_clk before the edge-detect flop.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/clk_down_chan.sv
// One transfer channel: buffers words from a fast producer and presents one word
// on outdata at each shared tick (detected slow_clk falling edge).
//
// Handshake: a word is taken on a clock edge where in_valid & in_ready are both 1.
// in_valid may be asserted at any time and need not wait for in_ready; in_ready
// never depends on in_valid. in_ready is 0 whenever reset is high.
module clk_down_chan
  import clk_down_pkg::*;
#(
  parameter int         WIDTH = 32,
  parameter int         DEPTH = 4,
  parameter xfer_mode_e MODE  = XFER_LATEST
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             tick,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] indata,
  output logic [WIDTH-1:0] outdata,
  output logic             out_valid,
  output logic             lost
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (MODE == XFER_LATEST) begin : g_latest

      logic [WIDTH-1:0] hold_q, hold_d;
      logic             hold_valid_q, hold_valid_d;
      logic             pend_q, pend_d;
      logic             lost_q, lost_d;
      logic [WIDTH-1:0] out_q, out_d;
      logic             out_valid_q, out_valid_d;
      logic             accept;

      assign in_ready = ~reset;
      assign accept   = in_valid & in_ready;

      // Next state: tick moves the held word out; an accept replaces the held word and
      // flags loss only if the previous word was never transferred.
      always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        pend_d       = pend_q;
        lost_d       = lost_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        if (tick) begin
          out_d       = hold_q;
          out_valid_d = hold_valid_q;
          pend_d      = 1'b0;
        end
        if (accept) begin
          hold_d       = indata;
          hold_valid_d = 1'b1;
          pend_d       = 1'b1;
          if (pend_q && !tick) begin
            lost_d = 1'b1;
          end
        end
      end

      // State registers with synchronous reset.
      always_ff @(posedge inclk) begin
        if (reset) begin
          hold_q       <= '0;
          hold_valid_q <= 1'b0;
          pend_q       <= 1'b0;
          lost_q       <= 1'b0;
          out_q        <= '0;
          out_valid_q  <= 1'b0;
        end else begin
          hold_q       <= hold_d;
          hold_valid_q <= hold_valid_d;
          pend_q       <= pend_d;
          lost_q       <= lost_d;
          out_q        <= out_d;
          out_valid_q  <= out_valid_d;
        end
      end

      assign outdata   = out_q;
      assign out_valid = out_valid_q;
      assign lost      = lost_q;

    end else begin : g_fifo

      logic [AW:0]      wr_q, wr_d;
      logic [AW:0]      rd_q, rd_d;
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [WIDTH-1:0] out_q, out_d;
      logic             out_valid_q, out_valid_d;
      logic             empty, full, push;

      // The extra pointer MSB distinguishes full from empty when the indices match.
      assign empty    = (wr_q == rd_q);
      assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      assign in_ready = ~full & ~reset;
      assign push     = in_valid & in_ready;

      // Next state: push writes at wr; a tick pops from rd only if the FIFO was
      // non-empty before this edge, so a same-cycle push into an empty FIFO waits a tick.
      always_comb begin
        mem_d       = mem_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (push) begin
          mem_d[wr_q[AW-1:0]] = indata;
          wr_d                = wr_q + (AW+1)'(1);
        end
        if (tick) begin
          out_valid_d = ~empty;
          if (!empty) begin
            out_d = mem_q[rd_q[AW-1:0]];
            rd_d  = rd_q + (AW+1)'(1);
          end
        end
      end

      // Pointer and output registers with synchronous reset.
      always_ff @(posedge inclk) begin
        if (reset) begin
          wr_q        <= '0;
          rd_q        <= '0;
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end else begin
          wr_q        <= wr_d;
          rd_q        <= rd_d;
          out_q       <= out_d;
          out_valid_q <= out_valid_d;
        end
      end

      // Storage array; contents are don't-care while the pointers say empty.
      always_ff @(posedge inclk) begin
        mem_q <= mem_d;
      end

      assign outdata   = out_q;
      assign out_valid = out_valid_q;
      assign lost      = 1'b0;

    end
  endgenerate

endmodule

// File: rtl/clk_down_mc.sv
// Multi-channel fast-to-slow transfer: slow_clk is sampled as data, its falling
// edge produces a one-cycle tick shared by all independent channels.
module clk_down_mc
  import clk_down_pkg::*;
#(
  parameter int         WIDTH = 32,
  parameter int         NCH   = 4,
  parameter int         DEPTH = 4,
  parameter xfer_mode_e MODE  = XFER_LATEST
) (
  input  logic                 inclk,
  input  logic                 reset,
  input  logic                 slow_clk,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] indata,
  output logic [NCH*WIDTH-1:0] outdata,
  output logic [NCH-1:0]       out_valid,
  output logic                 out_tick,
  output logic [NCH-1:0]       lost
);

  // sync_q[0..SYNC_STAGES-1] resynchronise slow_clk; the top bit is the delayed copy
  // used for falling-edge detection. Reset to 0 means a high slow_clk at reset exit
  // must fall before any tick can appear.
  logic [SYNC_STAGES:0] sync_q, sync_d;
  logic                 tick;

  // Shift slow_clk into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-1:0], slow_clk};
  end

  // Synchronizer registers with synchronous reset.
  always_ff @(posedge inclk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign tick     = sync_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1];
  assign out_tick = tick;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      clk_down_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .MODE  (MODE)
      ) u_chan (
        .inclk     (inclk),
        .reset     (reset),
        .tick      (tick),
        .in_valid  (in_valid[c]),
        .in_ready  (in_ready[c]),
        .indata    (indata[c*WIDTH +: WIDTH]),
        .outdata   (outdata[c*WIDTH +: WIDTH]),
        .out_valid (out_valid[c]),
        .lost      (lost[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_down_mc.sv
// Directed bench for clk_down_mc: one LATEST and one FIFO instance share the
// clock, reset and slow_clk; expected values are hand-computed constants.
module tb_clk_down_mc;
  import clk_down_pkg::*;

  localparam int W  = 8;
  localparam int NC = 2;

  // ---------------- clock / reset ----------------
  logic inclk = 1'b0;
  logic reset;
  logic slow_clk;
  logic slow_run;
  int   phase;

  always #5 inclk = ~inclk;

  // ---------------- DUT signals ----------------
  logic [NC-1:0]   in_valid_l, in_ready_l, out_valid_l, lost_l;
  logic [NC*W-1:0] indata_l, outdata_l;
  logic            tick_l;
  logic [NC-1:0]   in_valid_f, in_ready_f, out_valid_f, lost_f;
  logic [NC*W-1:0] indata_f, outdata_f;
  logic            tick_f;

  clk_down_mc #(.WIDTH(W), .NCH(NC), .DEPTH(4), .MODE(XFER_LATEST)) dut_l (
    .inclk     (inclk),
    .reset     (reset),
    .slow_clk  (slow_clk),
    .in_valid  (in_valid_l),
    .in_ready  (in_ready_l),
    .indata    (indata_l),
    .outdata   (outdata_l),
    .out_valid (out_valid_l),
    .out_tick  (tick_l),
    .lost      (lost_l)
  );

  clk_down_mc #(.WIDTH(W), .NCH(NC), .DEPTH(4), .MODE(XFER_FIFO)) dut_f (
    .inclk     (inclk),
    .reset     (reset),
    .slow_clk  (slow_clk),
    .in_valid  (in_valid_f),
    .in_ready  (in_ready_f),
    .indata    (indata_f),
    .outdata   (outdata_f),
    .out_valid (out_valid_f),
    .out_tick  (tick_f),
    .lost      (lost_f)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one inclk cycle; inputs and slow_clk change 1 time unit after the edge.
  task automatic step();
    @(posedge inclk);
    #1;
    if (slow_run) begin
      phase    = (phase + 1) % 8;
      slow_clk = (phase < 4);
    end
  endtask

  // Stop at the cycle where out_tick is high (the next edge performs the transfer).
  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick_l && n < 40) begin
      step();
      n++;
    end
    if (!tick_l) begin
      n_checks++;
      n_errors++;
      $display("FAIL tick_timeout: got no out_tick, expected one within 40 cycles at %0t", $time);
    end
  endtask

  // Stop right after slow_clk has been driven from 1 to 0.
  task automatic wait_fall();
    logic prev;
    for (int i = 0; i < 20; i++) begin
      prev = slow_clk;
      step();
      if (prev && !slow_clk) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL fall_timeout: got no slow_clk fall, expected one within 20 cycles");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    slow_run   = 1'b1;
    phase      = 2;
    slow_clk   = 1'b1;
    in_valid_l = '0;
    in_valid_f = '0;
    indata_l   = '0;
    indata_f   = '0;

    // 1: reset held 3 cycles while slow_clk falls
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tick_l", 32'(tick_l), 32'd0);
      check("rst_tick_f", 32'(tick_f), 32'd0);
    end
    check("rst_out_l",   32'(outdata_l),   32'h0);
    check("rst_ov_l",    32'(out_valid_l), 32'h0);
    check("rst_rdy_l",   32'(in_ready_l),  32'h0);
    check("rst_lost_l",  32'(lost_l),      32'h0);
    check("rst_out_f",   32'(outdata_f),   32'h0);
    check("rst_ov_f",    32'(out_valid_f), 32'h0);
    check("rst_rdy_f",   32'(in_ready_f),  32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy_l", 32'(in_ready_l), 32'h3);

    // 2: LATEST single push, latency from slow_clk fall
    in_valid_l = 2'b01;
    indata_l   = 16'h00A5;
    step();
    in_valid_l = '0;
    wait_fall();
    step();
    step();
    check("lat_tick_e2", 32'(tick_l), 32'd1);
    check("lat_out_e2",  32'(outdata_l[7:0]), 32'h00);
    step();
    check("lat_out_e3",  32'(outdata_l[7:0]), 32'hA5);
    check("lat_ov_e3",   32'(out_valid_l), 32'h1);
    wait_tick();
    step();
    check("hold_out",    32'(outdata_l[7:0]), 32'hA5);
    check("hold_ov",     32'(out_valid_l), 32'h1);
    check("hold_lost",   32'(lost_l), 32'h0);

    // 3: LATEST overwrite before transfer
    in_valid_l = 2'b01;
    indata_l   = 16'h0011;
    step();
    indata_l   = 16'h0022;
    step();
    in_valid_l = '0;
    check("ovw_lost_now", 32'(lost_l), 32'h1);
    wait_tick();
    step();
    check("ovw_out",   32'(outdata_l[7:0]), 32'h22);
    check("ovw_lost1", 32'(lost_l), 32'h1);
    wait_tick();
    step();
    check("ovw_lost2", 32'(lost_l), 32'h1);
    check("ovw_ov",    32'(out_valid_l), 32'h1);

    // 4: FIFO fill to full with no ticks, then drain
    check("f_idle_ov",   32'(out_valid_f), 32'h0);
    check("f_lost_tied", 32'(lost_f), 32'h0);
    slow_run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_f = 2'b01;
      indata_f   = {8'h00, 8'(i + 1)};
      check($sformatf("f_rdy_push%0d", i + 1), 32'(in_ready_f[0]), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    in_valid_f = '0;
    check("f_rdy_ch1", 32'(in_ready_f[1]), 32'd1);
    slow_run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_tick();
      step();
      check($sformatf("f_pop%0d_out", k), 32'(outdata_f[7:0]), 32'(k));
      check($sformatf("f_pop%0d_ov", k),  32'(out_valid_f), 32'h1);
    end
    check("f_rdy_after", 32'(in_ready_f[0]), 32'd1);
    wait_tick();
    step();
    check("f_empty_ov",  32'(out_valid_f), 32'h0);
    check("f_empty_out", 32'(outdata_f[7:0]), 32'h04);

    // 5: push into empty FIFO in the tick cycle
    wait_tick();
    in_valid_f = 2'b01;
    indata_f   = 16'h003C;
    step();
    in_valid_f = '0;
    check("f_same_ov",  32'(out_valid_f), 32'h0);
    check("f_same_out", 32'(outdata_f[7:0]), 32'h04);
    wait_tick();
    step();
    check("f_next_out", 32'(outdata_f[7:0]), 32'h3C);
    check("f_next_ov",  32'(out_valid_f), 32'h1);

    // 6: reset pulse with 3 words queued
    for (int i = 0; i < 3; i++) begin
      in_valid_f = 2'b01;
      indata_f   = {8'h00, 8'(8'h71 + i)};
      step();
    end
    in_valid_f = '0;
    reset = 1'b1;
    step();
    check("mr_out_f",  32'(outdata_f), 32'h0);
    check("mr_ov_f",   32'(out_valid_f), 32'h0);
    check("mr_lost_l", 32'(lost_l), 32'h0);
    reset = 1'b0;
    #1;
    check("mr_rdy_f", 32'(in_ready_f), 32'h3);
    wait_tick();
    step();
    check("mr_tick_ov",  32'(out_valid_f), 32'h0);
    check("mr_tick_out", 32'(outdata_f), 32'h0);
    check("mr_tick_ovl", 32'(out_valid_l), 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
